// File: rtl/or_reduce_pipe.sv
// or_reduce_pipe: multi-lane OR/NOR reduction built as a registered tree of
// FANIN-input OR levels, with a valid/ready handshake that stalls the whole
// pipeline at once and a per-lane sticky accumulator of delivered results.
module or_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int FANIN  = 4,
  parameter int INVERT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES-1:0]       y,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   acc_clr,
  output logic [LANES-1:0]       sticky
);

  // Number of live bits per lane after lvl tree levels (level 0 = raw input).
  function automatic int level_width(input int lvl);
    int n;
    n = WIDTH;
    for (int i = 0; i < lvl; i++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  // Tree depth; a single-bit lane still gets one register stage.
  function automatic int num_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (n > 1) begin
        n = (n + FANIN - 1) / FANIN;
        l = l + 1;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  localparam int LAT = num_levels();
  localparam int DW  = LANES * WIDTH;

  // Every stage keeps the full lane layout; bits above a level's live width
  // are always zero, so the last stage holds each lane result in bit 0.
  logic [LAT-1:0][DW-1:0] data_r;
  logic [LAT-1:0][DW-1:0] src_s;
  logic [LAT-1:0][DW-1:0] next_s;
  logic [LAT-1:0]         valid_r;
  logic [LAT-1:0]         vin_s;
  logic [LANES-1:0]       last_s;
  logic [LANES-1:0]       r_s;
  logic [LANES-1:0]       y_next_s;
  logic [LANES-1:0]       y_r;
  logic [LANES-1:0]       sticky_r;
  logic                   adv_s;
  logic                   xfer_s;

  assign adv_s     = !valid_r[LAT-1] || out_ready;
  assign xfer_s    = valid_r[LAT-1] && out_ready;
  assign in_ready  = adv_s;
  assign out_valid = valid_r[LAT-1];
  assign y         = y_r;
  assign sticky    = sticky_r;

  // Source of each stage: the input port for the first, the previous stage otherwise.
  always_comb begin
    src_s    = '0;
    vin_s    = '0;
    src_s[0] = a;
    vin_s[0] = in_valid;
    for (int k = 1; k < LAT; k++) begin
      src_s[k] = data_r[k-1];
      vin_s[k] = valid_r[k-1];
    end
  end

  // OR tree: group g of level k ORs source bits g*FANIN .. g*FANIN+FANIN-1, missing bits read as 0.
  always_comb begin : p_tree
    int   idx;
    logic hit;
    idx    = 0;
    hit    = 1'b0;
    next_s = '0;
    for (int k = 0; k < LAT; k++) begin
      for (int l = 0; l < LANES; l++) begin
        for (int g = 0; g < WIDTH; g++) begin
          for (int j = 0; j < FANIN; j++) begin
            hit = (g < level_width(k + 1)) && ((g * FANIN + j) < level_width(k));
            idx = hit ? (l * WIDTH + g * FANIN + j) : 0;
            next_s[k][l*WIDTH+g] = next_s[k][l*WIDTH+g] | (hit & src_s[k][idx]);
          end
        end
      end
    end
  end

  // Lane results: incoming last-stage value (for Y) and current last-stage value (for STICKY).
  always_comb begin
    last_s = '0;
    r_s    = '0;
    for (int l = 0; l < LANES; l++) begin
      last_s[l] = |next_s[LAT-1][l*WIDTH +: WIDTH];
      r_s[l]    = |data_r[LAT-1][l*WIDTH +: WIDTH];
    end
    y_next_s = (INVERT != 0) ? (~last_s & {LANES{vin_s[LAT-1]}}) : last_s;
  end

  // Pipeline registers: all stages advance together or all hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= '0;
      valid_r <= '0;
      y_r     <= '0;
    end else if (adv_s) begin
      data_r  <= next_s;
      valid_r <= vin_s;
      y_r     <= y_next_s;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
      y_r     <= y_r;
    end
  end

  // Sticky accumulator: optional clear, then OR in the un-inverted delivered beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (acc_clr ? {LANES{1'b0}} : sticky_r) | (xfer_s ? r_s : {LANES{1'b0}});
    end
  end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Directed bench for or_reduce_pipe: default OR instance, an INVERT=1
// instance and a WIDTH=13/FANIN=2/LANES=1 instance share clock and controls.
module tb_or_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        acc_clr;
  logic [31:0] a0;
  logic [31:0] a1;
  logic [12:0] a2;
  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [3:0]  y0, y1, sticky0, sticky1;
  logic        y2, sticky2;

  int n_checks;
  int n_fail;

  or_reduce_pipe #(.WIDTH(8), .LANES(4), .FANIN(4), .INVERT(0)) u_or (
    .clk(clk), .rst(rst), .a(a0), .in_valid(in_valid), .in_ready(in_ready0),
    .y(y0), .out_valid(out_valid0), .out_ready(out_ready), .acc_clr(acc_clr),
    .sticky(sticky0)
  );

  or_reduce_pipe #(.WIDTH(8), .LANES(4), .FANIN(4), .INVERT(1)) u_nor (
    .clk(clk), .rst(rst), .a(a1), .in_valid(in_valid), .in_ready(in_ready1),
    .y(y1), .out_valid(out_valid1), .out_ready(out_ready), .acc_clr(acc_clr),
    .sticky(sticky1)
  );

  or_reduce_pipe #(.WIDTH(13), .LANES(1), .FANIN(2), .INVERT(0)) u_w13 (
    .clk(clk), .rst(rst), .a(a2), .in_valid(in_valid), .in_ready(in_ready2),
    .y(y2), .out_valid(out_valid2), .out_ready(out_ready), .acc_clr(acc_clr),
    .sticky(sticky2)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    a0        = 32'h0;
    a1        = 32'h0;
    a2        = 13'h0;

    // Reset state
    step(); step();
    check("rst_ov",     32'(out_valid0), 32'h0);
    check("rst_ird",    32'(in_ready0),  32'h1);
    check("rst_y",      32'(y0),         32'h0);
    check("rst_sticky", 32'(sticky0),    32'h0);
    check("rst_y_inv",  32'(y1),         32'h0);
    rst = 1'b0;
    step();
    check("post_rst_y_inv", 32'(y1), 32'h0);

    // Back-to-back beats, latency 2
    a0 = 32'h0000_0100; in_valid = 1'b1;
    step();
    check("t1_lat_ov", 32'(out_valid0), 32'h0);
    a0 = 32'h0;
    step();
    check("t1_b0_ov", 32'(out_valid0), 32'h1);
    check("t1_b0_y",  32'(y0),         32'h2);
    in_valid = 1'b0;
    step();
    check("t1_b1_ov", 32'(out_valid0), 32'h1);
    check("t1_b1_y",  32'(y0),         32'h0);
    step();
    check("t1_idle_ov", 32'(out_valid0), 32'h0);

    // Stall with three beats
    a0 = 32'h0000_0001; in_valid = 1'b1;
    step();
    a0 = 32'h0000_0100; out_ready = 1'b0;
    check("t2_ird_pre", 32'(in_ready0), 32'h1);
    step();
    a0 = 32'h0001_0000;
    check("t2_ird_stall", 32'(in_ready0), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_ov",  32'(out_valid0), 32'h1);
      check("t2_hold_y",   32'(y0),         32'h1);
      check("t2_hold_ird", 32'(in_ready0),  32'h0);
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_b1_ov", 32'(out_valid0), 32'h1);
    check("t2_b1_y",  32'(y0),         32'h2);
    step();
    check("t2_b2_ov", 32'(out_valid0), 32'h1);
    check("t2_b2_y",  32'(y0),         32'h4);
    step();
    check("t2_end_ov", 32'(out_valid0), 32'h0);

    // Sticky accumulation and clear
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("t3_clr", 32'(sticky0), 32'h0);
    a0 = 32'h8000_0000; in_valid = 1'b1;
    step();
    a0 = 32'h0000_0001;
    step();
    a0 = 32'h0000_0100;
    step();
    in_valid = 1'b0;
    check("t3_s1", 32'(sticky0), 32'h8);
    step();
    check("t3_s2",   32'(sticky0), 32'h9);
    check("t3_b2_y", 32'(y0),      32'h2);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("t3_s3", 32'(sticky0), 32'h2);

    // INVERT=1 instance
    a1 = 32'hFF00_00FF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t4_ov", 32'(out_valid1), 32'h1);
    check("t4_y",  32'(y1),         32'h6);
    step();
    check("t4_sticky", 32'(sticky1),    32'h9);
    check("t4_idle_y", 32'(y1),         32'h0);
    check("t4_idle_ov", 32'(out_valid1), 32'h0);

    // Reset with beats in flight
    a0 = 32'hFFFF_FFFF; in_valid = 1'b1;
    step(); step(); step();
    check("t6_pre_ov",     32'(out_valid0), 32'h1);
    check("t6_pre_sticky", 32'(sticky0),    32'hF);
    check("t6_pre_y_inv",  32'(y1),         32'h6);
    rst = 1'b1;
    #1;
    check("t6_rst_ov",     32'(out_valid0), 32'h0);
    check("t6_rst_sticky", 32'(sticky0),    32'h0);
    check("t6_rst_y_inv",  32'(y1),         32'h0);
    in_valid = 1'b0;
    step();
    check("t6_rst_hold_y_inv", 32'(y1), 32'h0);
    rst = 1'b0;
    step();
    check("t6_post1_ov", 32'(out_valid0), 32'h0);
    step();
    check("t6_post2_ov",    32'(out_valid0), 32'h0);
    check("t6_post2_y_inv", 32'(y1),         32'h0);

    // WIDTH=13, FANIN=2: latency 4 for every bit position
    for (int i = 0; i < 13; i++) begin
      a2 = 13'd1 << i; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step(); step();
      check("t5_early_ov", 32'(out_valid2), 32'h0);
      step();
      check("t5_ov", 32'(out_valid2), 32'h1);
      check("t5_y",  32'(y2),         32'h1);
    end
    a2 = 13'h0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("t5_zero_ov", 32'(out_valid2), 32'h1);
    check("t5_zero_y",  32'(y2),         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
